id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_3000, value loaded into e_pc on reset and on bubble insertion.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  from the hazard unit; when high, a bubble is loaded instead of the D-stage instruction.
REQ-005 SHALL have ports: d_pc, d_instr, d_rs_data, d_rt_data, d_imm32  input  32 each  D-stage PC, instruction, register-file read data and extended immediate.
REQ-006 SHALL have ports: d_rs, d_rt, d_wa  input  5 each  source register numbers and destination register number.
REQ-007 SHALL have ports: d_aluop (3), d_alusrc, d_regwrite, d_memwrite, d_memtoreg (1 each), d_tnew (2)  input  D-stage control and cycles-until-result.
REQ-008 SHALL have ports: m_fwd_we (1), m_fwd_wa (5), m_fwd_data (32)  input  forwarding source from the M stage.
REQ-009 SHALL have ports: w_fwd_we (1), w_fwd_wa (5), w_fwd_data (32)  input  forwarding source from the W stage.
REQ-010 SHALL have ports: e_inA, e_inB  output  32  ALU operands; e_aluop  output  3  ALU op code.
REQ-011 SHALL have ports: e_pc, e_instr, e_st_data  output  32  registered PC, instruction, forwarded rt value for stores.
REQ-012 SHALL have ports: e_rs, e_rt, e_wa (5), e_regwrite, e_memwrite, e_memtoreg, e_valid (1), e_tnew (2), m_tnew_next (2)  output  hazard/pipeline control.

Function
REQ-013 SHALL, on rising clk with stall=0, register every d_* input into its E copy and set e_valid=1; latency D->E exactly one cycle.
REQ-014 SHALL, on rising clk with stall=1, load a bubble: instr=0, pc=RESET_PC, all data/immediate=0, rs=rt=wa=0, aluop=3'b000, all control bits=0, tnew=0, e_valid=0.
REQ-015 SHALL compute the rs operand combinationally: if e_rs!=0 and m_fwd_we and m_fwd_wa==e_rs then m_fwd_data; else if e_rs!=0 and w_fwd_we and w_fwd_wa==e_rs then w_fwd_data; else registered rs data.
REQ-016 SHALL compute the forwarded rt value with the same priority rule as REQ-015 using e_rt; e_st_data equals it.
REQ-017 SHALL drive e_inA with the forwarded rs value and e_inB with registered imm32 when e_alusrc=1, else the forwarded rt value.
REQ-018 SHALL never forward for register 0; reads of $0 always yield the registered value (0 from the regfile).
REQ-019 SHALL give M priority over W when both match the same register.
REQ-020 SHALL drive e_tnew from the register and m_tnew_next = e_tnew-1 saturating at 0 (0->0, 1->0, 2->1, 3->2).
REQ-021 SHALL treat the forwarding inputs as purely combinational paths (no registering, no added latency).
REQ-022 SHALL let stall take effect even if d_* carries a valid instruction; the D stage holds it (not this block's concern).

Reset
REQ-023 SHALL, while reset=1, immediately (asynchronously) force all registered state to bubble values of REQ-014, independent of clk.
REQ-024 SHALL give reset priority over stall and over normal load; the first load occurs on the first rising clk after reset deasserts.
REQ-025 SHALL, when reset asserts mid-instruction, discard the E-stage instruction with no partial state retained.

Verification
REQ-026 SHALL pass: reset=1 -> e_pc=32'h0000_3000, e_instr=0, e_valid=0, e_regwrite=0, e_tnew=0, without a clock edge.
REQ-027 SHALL pass: load addu $3,$1,$2, d_rs_data=5, d_rt_data=7, no forward matches -> next cycle e_inA=5, e_inB=7, e_wa=3, e_valid=1.
REQ-028 SHALL pass: E holds rs=1; m_fwd_we=1,m_fwd_wa=1,m_fwd_data=0x11; w_fwd_we=1,w_fwd_wa=1,w_fwd_data=0x22 -> e_inA=0x11; drop M match -> e_inA=0x22.
REQ-029 SHALL pass: E holds rs=0 with m_fwd_we=1, m_fwd_wa=0, m_fwd_data=0xDEAD -> e_inA=0.
REQ-030 SHALL pass: ori with d_alusrc=1, d_imm32=0x0000_FFFF, rt forwarded 0x1234 -> e_inB=0x0000_FFFF, e_st_data=0x1234.
REQ-031 SHALL pass: stall=1 on a valid lw with d_tnew=2 -> next cycle e_valid=0, e_memtoreg=0, e_tnew=0; stall=0 with d_tnew=2 -> e_tnew=2, m_tnew_next=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with M/W operand forwarding.
// Stall inserts a bubble. Reset asynchronously forces the stage to a bubble.
module id_ex_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] d_rt_data,
  input  logic [31:0] d_imm32,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [4:0]  d_wa,
  input  logic [2:0]  d_aluop,
  input  logic        d_alusrc,
  input  logic        d_regwrite,
  input  logic        d_memwrite,
  input  logic        d_memtoreg,
  input  logic [1:0]  d_tnew,
  input  logic        m_fwd_we,
  input  logic [4:0]  m_fwd_wa,
  input  logic [31:0] m_fwd_data,
  input  logic        w_fwd_we,
  input  logic [4:0]  w_fwd_wa,
  input  logic [31:0] w_fwd_data,
  output logic [31:0] e_inA,
  output logic [31:0] e_inB,
  output logic [2:0]  e_aluop,
  output logic [31:0] e_pc,
  output logic [31:0] e_instr,
  output logic [31:0] e_st_data,
  output logic [4:0]  e_rs,
  output logic [4:0]  e_rt,
  output logic [4:0]  e_wa,
  output logic        e_regwrite,
  output logic        e_memwrite,
  output logic        e_memtoreg,
  output logic        e_valid,
  output logic [1:0]  e_tnew,
  output logic [1:0]  m_tnew_next
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm32_q, imm32_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] wa_q, wa_d;
  logic [2:0]    aluop_q, aluop_d;
  logic          alusrc_q, alusrc_d;
  logic          regwrite_q, regwrite_d;
  logic          memwrite_q, memwrite_d;
  logic          memtoreg_q, memtoreg_d;
  logic          valid_q, valid_d;
  logic [1:0]    tnew_q, tnew_d;

  logic [DW-1:0] rs_fwd, rt_fwd;

  // Next-state: bubble on stall, otherwise capture the D-stage instruction.
  always_comb begin
    pc_d       = RESET_PC;
    instr_d    = '0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm32_d    = '0;
    rs_d       = '0;
    rt_d       = '0;
    wa_d       = '0;
    aluop_d    = 3'b000;
    alusrc_d   = 1'b0;
    regwrite_d = 1'b0;
    memwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    valid_d    = 1'b0;
    tnew_d     = 2'd0;
    if (!stall) begin
      pc_d       = d_pc;
      instr_d    = d_instr;
      rs_data_d  = d_rs_data;
      rt_data_d  = d_rt_data;
      imm32_d    = d_imm32;
      rs_d       = d_rs;
      rt_d       = d_rt;
      wa_d       = d_wa;
      aluop_d    = d_aluop;
      alusrc_d   = d_alusrc;
      regwrite_d = d_regwrite;
      memwrite_d = d_memwrite;
      memtoreg_d = d_memtoreg;
      valid_d    = 1'b1;
      tnew_d     = d_tnew;
    end
  end

  // Stage register; reset loads bubble values immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm32_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wa_q       <= '0;
      aluop_q    <= 3'b000;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      valid_q    <= 1'b0;
      tnew_q     <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm32_q    <= imm32_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wa_q       <= wa_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      valid_q    <= valid_d;
      tnew_q     <= tnew_d;
    end
  end

  // Operand forwarding: M beats W, register 0 never forwards.
  always_comb begin
    rs_fwd = rs_data_q;
    if (rs_q != '0 && m_fwd_we && m_fwd_wa == rs_q) begin
      rs_fwd = m_fwd_data;
    end else if (rs_q != '0 && w_fwd_we && w_fwd_wa == rs_q) begin
      rs_fwd = w_fwd_data;
    end
    rt_fwd = rt_data_q;
    if (rt_q != '0 && m_fwd_we && m_fwd_wa == rt_q) begin
      rt_fwd = m_fwd_data;
    end else if (rt_q != '0 && w_fwd_we && w_fwd_wa == rt_q) begin
      rt_fwd = w_fwd_data;
    end
  end

  // ALU operand select and saturating tnew decrement for the M stage.
  always_comb begin
    e_inA       = rs_fwd;
    e_inB       = alusrc_q ? imm32_q : rt_fwd;
    e_st_data   = rt_fwd;
    m_tnew_next = (tnew_q == 2'd0) ? 2'd0 : tnew_q - 2'd1;
  end

  assign e_pc       = pc_q;
  assign e_instr    = instr_q;
  assign e_aluop    = aluop_q;
  assign e_rs       = rs_q;
  assign e_rt       = rt_q;
  assign e_wa       = wa_q;
  assign e_regwrite = regwrite_q;
  assign e_memwrite = memwrite_q;
  assign e_memtoreg = memtoreg_q;
  assign e_valid    = valid_q;
  assign e_tnew     = tnew_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus randomized traffic
// compared against a behavioural model of the E-stage contents.
module tb_id_ex_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] d_pc, d_instr, d_rs_data, d_rt_data, d_imm32;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [2:0]  d_aluop;
  logic        d_alusrc, d_regwrite, d_memwrite, d_memtoreg;
  logic [1:0]  d_tnew;
  logic        m_fwd_we, w_fwd_we;
  logic [4:0]  m_fwd_wa, w_fwd_wa;
  logic [31:0] m_fwd_data, w_fwd_data;
  logic [31:0] e_inA, e_inB, e_pc, e_instr, e_st_data;
  logic [2:0]  e_aluop;
  logic [4:0]  e_rs, e_rt, e_wa;
  logic        e_regwrite, e_memwrite, e_memtoreg, e_valid;
  logic [1:0]  e_tnew, m_tnew_next;

  int n_pass = 0;
  int n_total = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .d_pc(d_pc), .d_instr(d_instr), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .d_imm32(d_imm32), .d_rs(d_rs), .d_rt(d_rt), .d_wa(d_wa), .d_aluop(d_aluop),
    .d_alusrc(d_alusrc), .d_regwrite(d_regwrite), .d_memwrite(d_memwrite),
    .d_memtoreg(d_memtoreg), .d_tnew(d_tnew),
    .m_fwd_we(m_fwd_we), .m_fwd_wa(m_fwd_wa), .m_fwd_data(m_fwd_data),
    .w_fwd_we(w_fwd_we), .w_fwd_wa(w_fwd_wa), .w_fwd_data(w_fwd_data),
    .e_inA(e_inA), .e_inB(e_inB), .e_aluop(e_aluop), .e_pc(e_pc), .e_instr(e_instr),
    .e_st_data(e_st_data), .e_rs(e_rs), .e_rt(e_rt), .e_wa(e_wa),
    .e_regwrite(e_regwrite), .e_memwrite(e_memwrite), .e_memtoreg(e_memtoreg),
    .e_valid(e_valid), .e_tnew(e_tnew), .m_tnew_next(m_tnew_next)
  );

  always #5 clk = ~clk;

  // Model of what the E stage holds.
  typedef struct {
    logic [31:0] pc, instr, rsd, rtd, imm;
    logic [4:0]  rs, rt, wa;
    logic [2:0]  aluop;
    logic        alusrc, rw, mw, mtr, valid;
    logic [1:0]  tnew;
  } est_t;

  est_t m;

  function automatic est_t bubble();
    est_t b;
    b.pc = RPC; b.instr = 0; b.rsd = 0; b.rtd = 0; b.imm = 0;
    b.rs = 0; b.rt = 0; b.wa = 0; b.aluop = 0;
    b.alusrc = 0; b.rw = 0; b.mw = 0; b.mtr = 0; b.valid = 0; b.tnew = 0;
    return b;
  endfunction

  // Value an instruction sees for register r given the bypass sources.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regval);
    if (r == 0) return regval;
    if (m_fwd_we && m_fwd_wa == r) return m_fwd_data;
    if (w_fwd_we && w_fwd_wa == r) return w_fwd_data;
    return regval;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    int tn;
    logic [31:0] a, b;
    a = operand(m.rs, m.rsd);
    b = operand(m.rt, m.rtd);
    tn = (int'(m.tnew) > 0) ? int'(m.tnew) - 1 : 0;
    chk("e_pc", e_pc, m.pc);
    chk("e_instr", e_instr, m.instr);
    chk("e_inA", e_inA, a);
    chk("e_inB", e_inB, m.alusrc ? m.imm : b);
    chk("e_st_data", e_st_data, b);
    chk("e_aluop", 32'(e_aluop), 32'(m.aluop));
    chk("e_rs", 32'(e_rs), 32'(m.rs));
    chk("e_rt", 32'(e_rt), 32'(m.rt));
    chk("e_wa", 32'(e_wa), 32'(m.wa));
    chk("e_regwrite", 32'(e_regwrite), 32'(m.rw));
    chk("e_memwrite", 32'(e_memwrite), 32'(m.mw));
    chk("e_memtoreg", 32'(e_memtoreg), 32'(m.mtr));
    chk("e_valid", 32'(e_valid), 32'(m.valid));
    chk("e_tnew", 32'(e_tnew), 32'(m.tnew));
    chk("m_tnew_next", 32'(m_tnew_next), 32'(tn));
  endtask

  // One clock: model captures D inputs on the rising edge, check on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset || stall) m = bubble();
    else begin
      m.pc = d_pc; m.instr = d_instr; m.rsd = d_rs_data; m.rtd = d_rt_data;
      m.imm = d_imm32; m.rs = d_rs; m.rt = d_rt; m.wa = d_wa; m.aluop = d_aluop;
      m.alusrc = d_alusrc; m.rw = d_regwrite; m.mw = d_memwrite;
      m.mtr = d_memtoreg; m.valid = 1'b1; m.tnew = d_tnew;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    stall = 0; d_pc = 0; d_instr = 0; d_rs_data = 0; d_rt_data = 0; d_imm32 = 0;
    d_rs = 0; d_rt = 0; d_wa = 0; d_aluop = 0; d_alusrc = 0; d_regwrite = 0;
    d_memwrite = 0; d_memtoreg = 0; d_tnew = 0;
    m_fwd_we = 0; m_fwd_wa = 0; m_fwd_data = 0;
    w_fwd_we = 0; w_fwd_wa = 0; w_fwd_data = 0;
  endtask

  task automatic randomize_inputs();
    stall = ($urandom_range(3) == 0);
    d_pc = $urandom; d_instr = $urandom; d_rs_data = $urandom; d_rt_data = $urandom;
    d_imm32 = $urandom;
    d_rs = 5'($urandom_range(3)); d_rt = 5'($urandom_range(3)); d_wa = 5'($urandom);
    d_aluop = 3'($urandom); d_alusrc = 1'($urandom); d_regwrite = 1'($urandom);
    d_memwrite = 1'($urandom); d_memtoreg = 1'($urandom); d_tnew = 2'($urandom);
    m_fwd_we = 1'($urandom); m_fwd_wa = 5'($urandom_range(3)); m_fwd_data = $urandom;
    w_fwd_we = 1'($urandom); w_fwd_wa = 5'($urandom_range(3)); w_fwd_data = $urandom;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    m = bubble();
    // Reset values visible before any clock edge.
    #1;
    chk("rst_pc", e_pc, 32'h0000_3000);
    chk("rst_instr", e_instr, 32'h0);
    chk("rst_valid", 32'(e_valid), 32'h0);
    chk("rst_regwrite", 32'(e_regwrite), 32'h0);
    chk("rst_tnew", 32'(e_tnew), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // addu $3,$1,$2 with no bypass hits.
    d_pc = 32'h0000_3004; d_instr = 32'h0022_1821;
    d_rs = 5'd1; d_rt = 5'd2; d_wa = 5'd3; d_rs_data = 32'd5; d_rt_data = 32'd7;
    d_regwrite = 1; d_tnew = 2'd1;
    step();
    chk("addu_inA", e_inA, 32'd5);
    chk("addu_inB", e_inB, 32'd7);
    chk("addu_wa", 32'(e_wa), 32'd3);
    chk("addu_valid", 32'(e_valid), 32'd1);

    // M beats W on the same register; W used once M drops.
    m_fwd_we = 1; m_fwd_wa = 5'd1; m_fwd_data = 32'h11;
    w_fwd_we = 1; w_fwd_wa = 5'd1; w_fwd_data = 32'h22;
    #1;
    chk("fwd_m_prio", e_inA, 32'h11);
    compare_all();
    m_fwd_we = 0;
    #1;
    chk("fwd_w", e_inA, 32'h22);
    compare_all();

    // Register 0 never forwards.
    @(negedge clk);
    clear_inputs();
    d_rs = 5'd0; d_rs_data = 32'd0; d_wa = 5'd4;
    step();
    m_fwd_we = 1; m_fwd_wa = 5'd0; m_fwd_data = 32'hDEAD;
    #1;
    chk("r0_no_fwd", e_inA, 32'h0);

    // ori: immediate to inB, forwarded rt to store data.
    @(negedge clk);
    clear_inputs();
    d_rs = 5'd6; d_rt = 5'd5; d_rs_data = 32'h9; d_rt_data = 32'h1;
    d_alusrc = 1; d_imm32 = 32'h0000_FFFF; d_aluop = 3'b011;
    step();
    m_fwd_we = 1; m_fwd_wa = 5'd5; m_fwd_data = 32'h1234;
    #1;
    chk("ori_inB", e_inB, 32'h0000_FFFF);
    chk("ori_st_data", e_st_data, 32'h1234);
    compare_all();

    // Stalled lw becomes a bubble, then the same lw loads.
    @(negedge clk);
    clear_inputs();
    d_pc = 32'h0000_3010; d_instr = 32'h8C22_0004; d_rs = 5'd1; d_wa = 5'd2;
    d_alusrc = 1; d_imm32 = 32'd4; d_regwrite = 1; d_memtoreg = 1; d_tnew = 2'd2;
    stall = 1;
    step();
    chk("stall_valid", 32'(e_valid), 32'd0);
    chk("stall_memtoreg", 32'(e_memtoreg), 32'd0);
    chk("stall_tnew", 32'(e_tnew), 32'd0);
    chk("stall_pc", e_pc, 32'h0000_3000);
    stall = 0;
    step();
    chk("lw_tnew", 32'(e_tnew), 32'd2);
    chk("lw_tnew_next", 32'(m_tnew_next), 32'd1);

    // Reset mid-instruction discards the E stage without a clock edge.
    #2;
    reset = 1'b1;
    m = bubble();
    #1;
    chk("mid_rst_valid", 32'(e_valid), 32'd0);
    chk("mid_rst_pc", e_pc, 32'h0000_3000);
    chk("mid_rst_memtoreg", 32'(e_memtoreg), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if ($urandom_range(40) == 0) begin
        reset = 1'b1;
        m = bubble();
        #1;
        compare_all();
      end
      step();
      reset = 1'b0;
      // Vary bypass sources mid-cycle to exercise the combinational paths.
      m_fwd_we = 1'($urandom); m_fwd_wa = 5'($urandom_range(3)); m_fwd_data = $urandom;
      w_fwd_we = 1'($urandom); w_fwd_wa = 5'($urandom_range(3)); w_fwd_data = $urandom;
      #1;
      compare_all();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
